// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes and controller states.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } state_e;

  // Size/alignment/range check applied to an incoming request.
  function automatic logic access_fault(input logic [1:0] size, input logic [31:0] addr,
                                        input logic [31:0] limit);
    logic f;
    f = (size == SZ_ILL) ||
        ((size == SZ_HALF) && addr[0]) ||
        ((size == SZ_WORD) && (addr[1:0] != 2'b00)) ||
        (addr >= limit);
    return f;
  endfunction

endpackage

// File: rtl/lsu_ctrl_lane.sv
// Little-endian lane steering: merges store data into an old word and
// extracts/extends load data. Purely combinational.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] merged,
  output logic [31:0] loaded
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [4:0]  shamt;

  always_comb begin
    shamt  = {offset, 3'b000};
    byte_v = old_word[shamt +: 8];
    half_v = offset[1] ? old_word[31:16] : old_word[15:0];
    merged = old_word;
    loaded = old_word;
    case (size)
      SZ_BYTE: begin
        merged[shamt +: 8] = wdata[7:0];
        loaded = {{24{~is_unsigned & byte_v[7]}}, byte_v};
      end
      SZ_HALF: begin
        if (offset[1]) merged[31:16] = wdata[15:0];
        else           merged[15:0]  = wdata[15:0];
        loaded = {{16{~is_unsigned & half_v[15]}}, half_v};
      end
      default: begin
        merged = wdata;
        loaded = old_word;
      end
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one request at a time, sub-word stores via read-modify-write,
// faulting accesses answered without touching memory.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_read,
  output logic        dm_write,
  input  logic [31:0] dm_rdata
);

  localparam logic [31:0] ADDR_LIMIT = 32'(ADDR_BYTES);

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        fault_q, fault_d;
  logic [31:0] old_word_q, old_word_d;

  logic        req_fault;
  logic [31:0] merged, loaded;
  logic [31:0] aligned_addr;

  lsu_lane u_lane (
    .size        (size_q),
    .offset      (addr_q[1:0]),
    .is_unsigned (uns_q),
    .old_word    (old_word_q),
    .wdata       (wdata_q),
    .merged      (merged),
    .loaded      (loaded)
  );

  always_comb begin
    req_fault  = access_fault(req_size, req_addr, ADDR_LIMIT);
    state_d    = state_q;
    write_d    = write_q;
    size_d     = size_q;
    uns_d      = uns_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    fault_d    = fault_q;
    old_word_d = old_word_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          fault_d = req_fault;
          if (req_fault)                             state_d = RESP;
          else if (req_write && req_size == SZ_WORD) state_d = WRITE;
          else                                       state_d = READ;
        end
      end
      READ: begin
        old_word_d = dm_rdata;
        state_d    = write_q ? WRITE : RESP;
      end
      WRITE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      fault_q    <= 1'b0;
      old_word_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      fault_q    <= fault_d;
      old_word_q <= old_word_d;
    end
  end

  // Strobes decode straight from the state flop so reset kills them asynchronously.
  assign aligned_addr = {addr_q[31:2], 2'b00};
  assign req_ready    = (state_q == IDLE);
  assign dm_read      = (state_q == READ);
  assign dm_write     = (state_q == WRITE);
  assign dm_addr      = (dm_read || dm_write) ? aligned_addr : 32'h0;
  assign dm_wdata     = dm_write ? merged : 32'h0;
  assign resp_valid   = (state_q == RESP);
  assign resp_fault   = resp_valid && fault_q;
  assign resp_rdata   = (resp_valid && !write_q && !fault_q) ? loaded : 32'h0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a word-wide memory model behind the dm_* port.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_rdata;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_read, dm_write;

  logic [31:0] mem [0:255];
  int          total_cnt = 0;
  int          pass_cnt  = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.ADDR_BYTES(1024)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_read(dm_read), .dm_write(dm_write), .dm_rdata(dm_rdata)
  );

  assign dm_rdata = mem[dm_addr[9:2]];
  always @(posedge clk) if (dm_write) mem[dm_addr[9:2]] <= dm_wdata;

  // Issues one request and observes until the response (or a 10-cycle bound).
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rdata, output logic flt,
                        output int nrd, output int nwr, output int wr_cyc,
                        output logic [31:0] wdat, output logic [31:0] waddr);
    lat = 0; rdata = 32'hx; flt = 1'bx; nrd = 0; nwr = 0; wr_cyc = 0;
    wdat = 32'h0; waddr = 32'h0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) req_valid = 1'b0;
      if (dm_read) nrd++;
      if (dm_write) begin
        nwr++; wr_cyc = n; wdat = dm_wdata; waddr = dm_addr;
      end
      if (resp_valid) begin
        lat = n; rdata = resp_rdata; flt = resp_fault;
        break;
      end
    end
  endtask

  task automatic test_reset;
    total_cnt += 4;
    if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", req_ready); else pass_cnt++;
    if ({resp_valid, resp_fault, dm_read, dm_write} !== 4'b0000)
      $display("FAIL reset_strobes: got %b expected 0000", {resp_valid, resp_fault, dm_read, dm_write});
    else pass_cnt++;
    if (resp_rdata !== 32'h0) $display("FAIL reset_rdata: got %h expected 0", resp_rdata); else pass_cnt++;
    if ({dm_addr, dm_wdata} !== 64'h0) $display("FAIL reset_dm_bus: got %h expected 0", {dm_addr, dm_wdata}); else pass_cnt++;
  endtask

  task automatic test_load_byte;
    int lat, nrd, nwr, wc; logic [31:0] rd, wdt, wa; logic f;
    do_req(1'b0, SZ_BYTE, 1'b0, 32'h103, 32'h0, lat, rd, f, nrd, nwr, wc, wdt, wa);
    total_cnt += 4;
    if (lat !== 2) $display("FAIL lb_latency: got %0d expected 2", lat); else pass_cnt++;
    if (rd !== 32'hFFFF_FF88) $display("FAIL lb_signed: got %h expected ffffff88", rd); else pass_cnt++;
    if (f !== 1'b0) $display("FAIL lb_fault: got %b expected 0", f); else pass_cnt++;
    if (nrd !== 1 || nwr !== 0) $display("FAIL lb_strobes: got rd=%0d wr=%0d expected rd=1 wr=0", nrd, nwr); else pass_cnt++;
    do_req(1'b0, SZ_BYTE, 1'b1, 32'h103, 32'h0, lat, rd, f, nrd, nwr, wc, wdt, wa);
    total_cnt++;
    if (rd !== 32'h0000_0088) $display("FAIL lbu_unsigned: got %h expected 00000088", rd); else pass_cnt++;
  endtask

  task automatic test_half_store;
    int lat, nrd, nwr, wc; logic [31:0] rd, wdt, wa; logic f;
    do_req(1'b1, SZ_HALF, 1'b0, 32'h102, 32'h0000_ABCD, lat, rd, f, nrd, nwr, wc, wdt, wa);
    total_cnt += 5;
    if (lat !== 3) $display("FAIL sh_latency: got %0d expected 3", lat); else pass_cnt++;
    if (wdt !== 32'hABCD_6655) $display("FAIL sh_merge: got %h expected abcd6655", wdt); else pass_cnt++;
    if (wa !== 32'h100) $display("FAIL sh_addr: got %h expected 00000100", wa); else pass_cnt++;
    if (nrd !== 1 || nwr !== 1 || wc !== 2)
      $display("FAIL sh_strobes: got rd=%0d wr=%0d at %0d expected rd=1 wr=1 at 2", nrd, nwr, wc);
    else pass_cnt++;
    if (rd !== 32'h0) $display("FAIL sh_rdata: got %h expected 0", rd); else pass_cnt++;
    do_req(1'b0, SZ_HALF, 1'b0, 32'h102, 32'h0, lat, rd, f, nrd, nwr, wc, wdt, wa);
    total_cnt++;
    if (rd !== 32'hFFFF_ABCD) $display("FAIL lh_signed: got %h expected ffffabcd", rd); else pass_cnt++;
    do_req(1'b0, SZ_HALF, 1'b1, 32'h100, 32'h0, lat, rd, f, nrd, nwr, wc, wdt, wa);
    total_cnt++;
    if (rd !== 32'h0000_6655) $display("FAIL lhu_low: got %h expected 00006655", rd); else pass_cnt++;
  endtask

  task automatic test_word_store;
    int lat, nrd, nwr, wc; logic [31:0] rd, wdt, wa; logic f;
    do_req(1'b1, SZ_WORD, 1'b0, 32'h004, 32'hDEAD_BEEF, lat, rd, f, nrd, nwr, wc, wdt, wa);
    total_cnt += 3;
    if (lat !== 2) $display("FAIL sw_latency: got %0d expected 2", lat); else pass_cnt++;
    if (nrd !== 0 || nwr !== 1 || wc !== 1)
      $display("FAIL sw_strobes: got rd=%0d wr=%0d at %0d expected rd=0 wr=1 at 1", nrd, nwr, wc);
    else pass_cnt++;
    if (wdt !== 32'hDEAD_BEEF || wa !== 32'h4)
      $display("FAIL sw_bus: got %h@%h expected deadbeef@00000004", wdt, wa);
    else pass_cnt++;
    do_req(1'b0, SZ_WORD, 1'b1, 32'h004, 32'h0, lat, rd, f, nrd, nwr, wc, wdt, wa);
    total_cnt++;
    if (rd !== 32'hDEAD_BEEF) $display("FAIL lw_readback: got %h expected deadbeef", rd); else pass_cnt++;
  endtask

  task automatic test_faults;
    int lat, nrd, nwr, wc; logic [31:0] rd, wdt, wa; logic f;
    logic [1:0]  sz_v [4] = '{SZ_WORD, SZ_HALF, SZ_ILL, SZ_BYTE};
    logic [31:0] ad_v [4] = '{32'h102, 32'h001, 32'h000, 32'h400};
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, sz_v[i], 1'b0, ad_v[i], 32'h0, lat, rd, f, nrd, nwr, wc, wdt, wa);
      total_cnt++;
      if (lat !== 1 || f !== 1'b1 || rd !== 32'h0 || nrd !== 0 || nwr !== 0)
        $display("FAIL fault_%0d: got lat=%0d fault=%b rdata=%h rd=%0d wr=%0d expected lat=1 fault=1 rdata=0 rd=0 wr=0",
                 i, lat, f, rd, nrd, nwr);
      else pass_cnt++;
    end
    do_req(1'b1, SZ_WORD, 1'b0, 32'h3FC, 32'h1234_5678, lat, rd, f, nrd, nwr, wc, wdt, wa);
    total_cnt++;
    if (lat !== 2 || f !== 1'b0 || nwr !== 1) $display("FAIL top_word_ok: got lat=%0d fault=%b wr=%0d expected 2/0/1", lat, f, nwr);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_op;
    int lat, nrd, nwr, wc, nresp; logic [31:0] rd, wdt, wa; logic f;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = SZ_BYTE; req_unsigned = 1'b0;
    req_addr = 32'h101; req_wdata = 32'h0000_005A;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (dm_write !== 1'b1) $display("FAIL rmo_in_write: got %b expected 1", dm_write); else pass_cnt++;
    #1 rst = 1'b1;
    #1;
    total_cnt++;
    if (dm_write !== 1'b0 || resp_valid !== 1'b0)
      $display("FAIL rmo_abort: got wr=%b resp=%b expected 0/0", dm_write, resp_valid);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    nresp = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (resp_valid) nresp++;
    end
    total_cnt += 3;
    if (req_ready !== 1'b1) $display("FAIL rmo_ready: got %b expected 1", req_ready); else pass_cnt++;
    if (nresp !== 0) $display("FAIL rmo_no_resp: got %0d expected 0", nresp); else pass_cnt++;
    if (mem[8'h40] !== 32'hABCD_6655) $display("FAIL rmo_mem_kept: got %h expected abcd6655", mem[8'h40]); else pass_cnt++;
    do_req(1'b1, SZ_BYTE, 1'b0, 32'h101, 32'h0000_005A, lat, rd, f, nrd, nwr, wc, wdt, wa);
    @(negedge clk);
    total_cnt++;
    if (mem[8'h40] !== 32'hABCD_5A55) $display("FAIL rmo_reissue: got %h expected abcd5a55", mem[8'h40]); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [1:0]  sz_v [3] = '{SZ_WORD, SZ_WORD, SZ_BYTE};
    logic [31:0] ad_v [3] = '{32'h100, 32'h004, 32'h103};
    logic [31:0] got [3];
    int idx = 0, nresp = 0, nrd = 0, viol = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (resp_valid) begin
        if (nresp < 3) got[nresp] = resp_rdata;
        nresp++;
      end
      if (dm_read) nrd++;
      if (req_ready && (dm_read || resp_valid)) viol++;
      if (req_ready) begin
        if (idx < 3) begin
          req_valid = 1'b1; req_write = 1'b0; req_size = sz_v[idx]; req_unsigned = 1'b0;
          req_addr = ad_v[idx]; req_wdata = 32'h0;
          idx++;
        end else begin
          req_valid = 1'b0;
          if (nresp >= 3) break;
        end
      end
    end
    req_valid = 1'b0;
    total_cnt += 3;
    if (nresp !== 3 || nrd !== 3) $display("FAIL b2b_count: got resp=%0d reads=%0d expected 3/3", nresp, nrd); else pass_cnt++;
    if (viol !== 0) $display("FAIL b2b_ready_busy: got %0d expected 0", viol); else pass_cnt++;
    if (got[0] !== 32'hABCD_5A55 || got[1] !== 32'hDEAD_BEEF || got[2] !== 32'hFFFF_FFAB)
      $display("FAIL b2b_order: got %h %h %h expected abcd5a55 deadbeef ffffffab", got[0], got[1], got[2]);
    else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h40] = 32'h8877_6655;
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    #1;
    test_reset;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset;
    test_load_byte;
    test_half_store;
    test_word_store;
    test_faults;
    test_reset_mid_op;
    test_back_to_back;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
